serial_bit_feeder: RTL and testbench
====================================

# serial_bit_feeder

Parallel-to-serial front end for the 1101 sequence detection path. It accepts W-bit words over a valid/ready handshake and shifts them out one bit per clock on `x`. This serial stream is the direct input of the Moore 1101 detector. The block qualifies each bit with `x_valid` and marks the final bit of each word with `x_last`.

## Interface
- `W`, default 8: word width in bits; legal range 2..32.
- `MSB_FIRST`, default 1: 1 sends bit W-1 first; 0 sends bit 0 first.

- `clk`  input  1: single clock; all state updates on the rising edge.
- `rst`  input  1: reset, asynchronous and active-low (0 = in reset).
- `in_data`  input  W: word to serialise; sampled on the accepting edge only.
- `in_valid`  input  1: producer has a word on `in_data`.
- `in_ready`  output  1: block can accept a word this cycle.
- `x`  output  1: serial bit to the detector; registered.
- `x_valid`  output  1: `x` carries a live bit this cycle; registered.
- `x_last`  output  1: current bit is the final bit of its word; registered.

## Operation
- A word is accepted on a rising edge where `in_valid && in_ready`.
- The producer must hold `in_data` stable while `in_valid` is 1 and `in_ready` is 0.
- The FSM has two states:
  - IDLE: `x_valid=0`.
  - SHIFT: `x_valid=1`.
- Transitions:
  - IDLE -> SHIFT on accept.
  - SHIFT -> SHIFT while `bit_cnt < W-1`, or when `bit_cnt == W-1` and a next word is available.
  - SHIFT -> IDLE when `bit_cnt == W-1` and no next word is available.
- `bit_cnt` has width clog2(W). It is 0 on the first bit and increments once per SHIFT cycle.
- `x_last = (bit_cnt == W-1)` while in SHIFT.
- The shift register loads the word on entry to SHIFT, then shifts one position per cycle in the direction set by `MSB_FIRST`.
- `x` is forced to 0 and `x_last` is forced to 0 whenever `x_valid=0`.
- `in_valid` asserted in reset is ignored. After `rst` deasserts, the first accept can occur on the first rising edge.
- If `rst` is asserted mid-word, the partial word is discarded immediately:
  - `x`, `x_valid`, `x_last` go to 0 asynchronously.
  - No resumption of the word after reset.

## Timing
- Reset values:
  - `x=0`, `x_valid=0`, `x_last=0`, FSM=IDLE, `bit_cnt=0`, hold register empty.
  - `in_ready=0` while `rst=0`.
- Latency: a word accepted at edge N produces its first bit on `x`, with `x_valid=1`, in the cycle after edge N. The final bit follows W-1 cycles later.
- `in_ready` is combinational from registered state only, with no path from `in_valid`.
- Without `SER_DOUBLE_BUFFER_EN`:
  - `in_ready = rst && (state == IDLE)`.
  - Back-to-back words have a 1-cycle gap (`x_valid=0`) between them, so the period is W+1 cycles.
- With `SER_DOUBLE_BUFFER_EN`: see Configuration. Words stream with no gap, period W cycles.
- When accept and last-bit shift-out fall on the same edge, both complete. The accepted word is not lost, and the current word is not truncated.

## Configuration
- Macro: `SER_DOUBLE_BUFFER_EN`.
- When defined, the block adds a 1-entry hold register with a full flag:
  - `in_ready = rst && !hold_full`.
  - A word can be accepted during SHIFT.
  - At the `x_last` edge, the shifter reloads from the hold register if it is full, and `hold_full` clears. The first bit of the next word appears on the following cycle.
  - An accept on an edge where the hold register also empties is legal. In IDLE, an accepted word bypasses the hold register straight into the shifter.
- When undefined, there is no hold register and behaviour matches Timing exactly.

## Test plan
- Reset: hold `rst=0` for 2 cycles with `in_valid=1` -> `x=0`, `x_valid=0`, `x_last=0`, `in_ready=0`, and nothing is accepted.
- Single word: `in_data=8'hD0` (1101_0000), `MSB_FIRST=1` -> `x` = 1,1,0,1,0,0,0,0 on 8 consecutive cycles with `x_valid=1`, `x_last` only on the 8th. The downstream detector asserts `y` after the 4th bit.
- Back-to-back words: `8'hDB` then `8'h6D` with `in_valid` held high:
  - Without the macro: 8 bits, 1 idle cycle, then 8 bits.
  - With the macro: 16 contiguous bits, `x_last` on cycles 8 and 16.
- Bit order: `MSB_FIRST=0`, `in_data=8'h0B` -> `x` = 1,1,0,1,0,0,0,0.
- Backpressure: assert `in_valid` during SHIFT (macro undefined) -> `in_ready` stays 0 until IDLE, and `in_data` is sampled only at the accept edge.
- Mid-word reset: drop `rst` after the 3rd bit of `8'hFF` -> outputs go to 0 immediately. After release, a new word `8'h0D` shifts out cleanly with no residue from `8'hFF`.

Source files
------------

// File: rtl/serial_bit_feeder.sv
// -----------------------------------------------------------------------------
// serial_bit_feeder
//
// Parallel-to-serial front end for the 1101 sequence detector. Words arrive
// over a valid/ready handshake and leave one bit per clock on x, with x_valid
// qualifying each bit and x_last marking the final bit of each word.
//
// Parameters:
//   W         - word width in bits (2..32)
//   MSB_FIRST - 1: bit W-1 leaves first; 0: bit 0 leaves first
//
// Ports:
//   clk      - clock, rising edge
//   rst      - asynchronous active-low reset (0 = in reset)
//   in_data  - word to serialise, sampled on the accepting edge only
//   in_valid - producer has a word on in_data
//   in_ready - block can accept a word this cycle (from registered state only)
//   x        - serial bit to the detector (registered)
//   x_valid  - x carries a live bit (registered)
//   x_last   - current bit is the final bit of its word (registered)
//
// Build option:
//   SER_DOUBLE_BUFFER_EN - adds a one-entry hold register so that words stream
//                          with no idle gap (period W instead of W+1).
// -----------------------------------------------------------------------------
module serial_bit_feeder #(
    parameter int unsigned W         = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic         x,
    output logic         x_valid,
    output logic         x_last
);

    localparam int unsigned     CntW    = (W > 1) ? $clog2(W) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(W - 1);

    typedef enum logic [0:0] {
        StIdle,
        StShift
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [W-1:0]    shift_q, shift_d;
    logic            x_q, x_d;
    logic            x_valid_q, x_valid_d;
    logic            x_last_q, x_last_d;
    logic            accept;
    logic            last_bit;

    // Advance the shifter by one position towards the output end.
    function automatic logic [W-1:0] shift_once(input logic [W-1:0] v);
        if (MSB_FIRST) begin
            return {v[W-2:0], 1'b0};
        end else begin
            return {1'b0, v[W-1:1]};
        end
    endfunction

    // Bit currently presented at the output end of the shifter.
    function automatic logic head_bit(input logic [W-1:0] v);
        if (MSB_FIRST) begin
            return v[W-1];
        end else begin
            return v[0];
        end
    endfunction

    assign last_bit = (state_q == StShift) && (cnt_q == LastCnt);

`ifdef SER_DOUBLE_BUFFER_EN
    logic [W-1:0] hold_q, hold_d;
    logic         hold_full_q, hold_full_d;

    // Readiness depends only on the hold slot, so a word can be taken while
    // the shifter is still busy with the previous one.
    assign in_ready = rst && !hold_full_q;
`else
    assign in_ready = rst && (state_q == StIdle);
`endif

    assign accept = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
`ifdef SER_DOUBLE_BUFFER_EN
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
`endif

        unique case (state_q)
            StIdle: begin
                // In IDLE an accepted word goes straight into the shifter.
                if (accept) begin
                    state_d = StShift;
                    cnt_d   = '0;
                    shift_d = in_data;
                end
            end

            StShift: begin
                if (!last_bit) begin
                    cnt_d   = cnt_q + 1'b1;
                    shift_d = shift_once(shift_q);
`ifdef SER_DOUBLE_BUFFER_EN
                    if (accept) begin
                        hold_d      = in_data;
                        hold_full_d = 1'b1;
                    end
`endif
                end else begin
`ifdef SER_DOUBLE_BUFFER_EN
                    // Last bit leaving: reload from the hold slot if it has a
                    // word, otherwise take a word being accepted this edge.
                    if (hold_full_q) begin
                        shift_d     = hold_q;
                        cnt_d       = '0;
                        hold_full_d = accept;
                        if (accept) begin
                            hold_d = in_data;
                        end
                    end else if (accept) begin
                        shift_d = in_data;
                        cnt_d   = '0;
                    end else begin
                        state_d = StIdle;
                        cnt_d   = '0;
                    end
`else
                    state_d = StIdle;
                    cnt_d   = '0;
`endif
                end
            end

            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    // Output registers are computed from the next state so that they line up
    // with the shifter contents in the same cycle.
    always_comb begin
        x_valid_d = (state_d == StShift);
        x_d       = x_valid_d && head_bit(shift_d);
        x_last_d  = x_valid_d && (cnt_d == LastCnt);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            shift_q   <= '0;
            x_q       <= 1'b0;
            x_valid_q <= 1'b0;
            x_last_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            x_q       <= x_d;
            x_valid_q <= x_valid_d;
            x_last_q  <= x_last_d;
        end
    end

`ifdef SER_DOUBLE_BUFFER_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_q      <= '0;
            hold_full_q <= 1'b0;
        end else begin
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
        end
    end
`endif

    assign x       = x_q;
    assign x_valid = x_valid_q;
    assign x_last  = x_last_q;

endmodule

// File: tb/tb_serial_bit_feeder.sv
module tb_serial_bit_feeder;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       x;
    logic       x_valid;
    logic       x_last;

    // Second instance for LSB-first bit order.
    logic [7:0] lin_data;
    logic       lin_valid;
    logic       lin_ready;
    logic       lx;
    logic       lx_valid;
    logic       lx_last;

    int n_total = 0;
    int n_bad   = 0;

    // Each entry: {expected x, expected x_last}.
    logic [1:0] exp_q[$];

    typedef struct {
        logic [7:0] data;
        logic [7:0] pat;   // expected serial bits, first bit in pat[7]
    } vec_t;

    vec_t vecs[6];

    serial_bit_feeder #(.W(8), .MSB_FIRST(1'b1)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .x        (x),
        .x_valid  (x_valid),
        .x_last   (x_last)
    );

    serial_bit_feeder #(.W(8), .MSB_FIRST(1'b0)) u_lsb (
        .clk      (clk),
        .rst      (rst),
        .in_data  (lin_data),
        .in_valid (lin_valid),
        .in_ready (lin_ready),
        .x        (lx),
        .x_valid  (lx_valid),
        .x_last   (lx_last)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        n_total++;
        n_bad++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // Scoreboard consumer: every live bit must match the head of the queue.
    always @(negedge clk) begin
        logic [1:0] e;
        if (x_valid) begin
            if (exp_q.size() == 0) begin
                fail("unexpected_bit");
            end else begin
                e = exp_q.pop_front();
                check("x_bit", {31'd0, x}, {31'd0, e[1]});
                check("x_last", {31'd0, x_last}, {31'd0, e[0]});
            end
        end else begin
            check("idle_x", {31'd0, x}, 32'd0);
            check("idle_last", {31'd0, x_last}, 32'd0);
        end
    end

    // Offer a word; push its expected bits when it is accepted.
    task automatic put_word(input logic [7:0] data, input logic [7:0] pat);
        bit got = 1'b0;
        in_data  = data;
        in_valid = 1'b1;
        for (int k = 0; k < 64 && !got; k++) begin
            if (in_ready) begin
                for (int i = 0; i < 8; i++) exp_q.push_back({pat[7-i], (i == 7)});
                got = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if (!got) fail("accept_timeout");
        in_valid = 1'b0;
        in_data  = ~data;   // anything after the accept edge must be ignored
    endtask

    task automatic drain();
        for (int k = 0; k < 100 && exp_q.size() != 0; k++) @(posedge clk);
        if (exp_q.size() != 0) fail("drain_timeout");
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [16:0] vpat;
        logic [16:0] rpat;
        logic [16:0] vexp;
        logic [7:0]  lpat;

        vecs[0] = '{data: 8'hD0, pat: 8'b1101_0000};
        vecs[1] = '{data: 8'hDB, pat: 8'b1101_1011};
        vecs[2] = '{data: 8'h6D, pat: 8'b0110_1101};
        vecs[3] = '{data: 8'h0B, pat: 8'b0000_1011};
        vecs[4] = '{data: 8'h01, pat: 8'b0000_0001};
        vecs[5] = '{data: 8'h80, pat: 8'b1000_0000};

        // Reset with in_valid high: nothing may be accepted.
        rst       = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'hAA;
        lin_valid = 1'b0;
        lin_data  = 8'h00;
        repeat (2) begin
            @(negedge clk);
            check("rst_in_ready", {31'd0, in_ready}, 32'd0);
            check("rst_x", {31'd0, x}, 32'd0);
            check("rst_x_valid", {31'd0, x_valid}, 32'd0);
            check("rst_x_last", {31'd0, x_last}, 32'd0);
        end

        // Release mid-cycle; the first rising edge after release accepts.
        in_data = 8'hD0;
        rst     = 1'b1;
        #1;
        check("ready_after_rst", {31'd0, in_ready}, 32'd1);
        put_word(8'hD0, 8'b1101_0000);
        check("first_bit_valid", {31'd0, x_valid}, 32'd1);
        check("first_bit_x", {31'd0, x}, 32'd1);
        drain();

        // Table of single words.
        for (int v = 0; v < 6; v++) begin
            put_word(vecs[v].data, vecs[v].pat);
            drain();
        end

        // Back-to-back words with in_valid held high.
        fork
            begin
                put_word(8'hDB, 8'b1101_1011);
                put_word(8'h6D, 8'b0110_1101);
            end
            begin
                for (int k = 0; k < 50 && !x_valid; k++) @(negedge clk);
                for (int k = 16; k >= 0; k--) begin
                    vpat[k] = x_valid;
                    rpat[k] = in_ready;
                    if (k != 0) @(negedge clk);
                end
            end
        join
`ifdef SER_DOUBLE_BUFFER_EN
        vexp = {16'hFFFF, 1'b0};
        check("b2b_valid_pattern", {15'd0, vpat}, {15'd0, vexp});
`else
        vexp = {8'hFF, 1'b0, 8'hFF};
        check("b2b_valid_pattern", {15'd0, vpat}, {15'd0, vexp});
        // Ready stays low for the whole of each word and only rises in IDLE.
        check("b2b_ready_pattern", {15'd0, rpat}, {15'd0, ~vexp});
`endif
        drain();

        // LSB-first: 8'h0B must leave as 1,1,0,1,0,0,0,0.
        lpat = 8'b1101_0000;
        check("lsb_ready", {31'd0, lin_ready}, 32'd1);
        lin_data  = 8'h0B;
        lin_valid = 1'b1;
        @(posedge clk);
        #1;
        lin_valid = 1'b0;
        lin_data  = 8'hFF;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("lsb_valid", {31'd0, lx_valid}, 32'd1);
            check("lsb_bit", {31'd0, lx}, {31'd0, lpat[7-i]});
            check("lsb_last", {31'd0, lx_last}, (i == 7) ? 32'd1 : 32'd0);
        end
        @(negedge clk);
        check("lsb_done", {31'd0, lx_valid}, 32'd0);
        @(posedge clk);
        #1;

        // Mid-word reset after the third bit of 8'hFF.
        put_word(8'hFF, 8'hFF);
        repeat (3) @(negedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("midrst_x", {31'd0, x}, 32'd0);
        check("midrst_valid", {31'd0, x_valid}, 32'd0);
        check("midrst_last", {31'd0, x_last}, 32'd0);
        check("midrst_ready", {31'd0, in_ready}, 32'd0);
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        put_word(8'h0D, 8'b0000_1101);
        drain();
        repeat (3) @(posedge clk);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
